// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU commands, drives them one at a time onto registered
// operand lines and captures the ALU result. The result is then offered downstream with an issue tag.
// Latency: command accepted at edge N -> operands driven after N+1 -> res_valid after N+2.
// Backpressure: res_ready=0 parks the result in HOLD and the queue fills; cmd_ready = !full.
// Optional feature macro: ALU_ISSUE_CHAIN_EN (adds cmd_chain, operand a taken from last result).
//
// Ports: clk/rst_n (async active-low); cmd_* upstream valid/ready command;
//        alu_a/alu_b/alu_ctrl/alu_s registered ALU operands, alu_y combinational result back;
//        res_valid/res_ready/res_data/res_seq downstream result; busy, fifo_level status.

// fifo: generic single-clock FIFO, DEPTH a power of two.
// Latency: head visible on pop_dat the cycle after the push edge; no bypass.
// Backpressure: push_rdy low while full; pop_vld low while empty.
module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_vld,
   output logic                     push_rdy,
   input  logic [W-1:0]             push_dat,
   output logic                     pop_vld,
   input  logic                     pop_rdy,
   output logic [W-1:0]             pop_dat,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign push_rdy = (level != FULL_LVL);
   assign pop_vld  = (level != '0);
   assign do_push  = push_vld && push_rdy;
   assign do_pop   = pop_rdy && pop_vld;
   assign pop_dat  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end
endmodule

// alu_issue_ctrl: command FIFO + IDLE/DRIVE/HOLD issue FSM around a combinational ALU.
// Latency: 2 cycles from command acceptance to res_valid; one result per 2 cycles.
// Backpressure: result held in HOLD until res_ready; cmd_ready drops when FIFO full.
module alu_issue_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [WIDTH-1:0]       cmd_a,
   input  logic [WIDTH-1:0]       cmd_b,
   input  logic                   cmd_ctrl,
   input  logic [1:0]             cmd_s,
`ifdef ALU_ISSUE_CHAIN_EN
   input  logic                   cmd_chain,
`endif
   output logic [WIDTH-1:0]       alu_a,
   output logic [WIDTH-1:0]       alu_b,
   output logic                   alu_ctrl,
   output logic [1:0]             alu_s,
   input  logic [WIDTH-1:0]       alu_y,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [WIDTH-1:0]       res_data,
   output logic [7:0]             res_seq,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_level
);
   typedef struct packed {
`ifdef ALU_ISSUE_CHAIN_EN
      logic             chain;
`endif
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             ctrl;
      logic [1:0]       s;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

   state_t                 state;
   cmd_t                   push_cmd;
   cmd_t                   head;
   logic [$bits(cmd_t)-1:0] head_raw;
   logic                   head_vld;
   logic                   pop;
   logic [WIDTH-1:0]       next_a;
   logic [7:0]             issue_cnt;

   always_comb begin
      push_cmd       = '0;
      push_cmd.a     = cmd_a;
      push_cmd.b     = cmd_b;
      push_cmd.ctrl  = cmd_ctrl;
      push_cmd.s     = cmd_s;
`ifdef ALU_ISSUE_CHAIN_EN
      push_cmd.chain = cmd_chain;
`endif
   end

   assign head = cmd_t'(head_raw);

   // Pop only when the FSM can take a new command: from IDLE, or from HOLD as the
   // current result is consumed. Never in DRIVE, so alu_* stay stable there.
   assign pop = head_vld && ((state == IDLE) || ((state == HOLD) && res_ready));

`ifdef ALU_ISSUE_CHAIN_EN
   // Chained commands take the result still in res_data (the one being consumed).
   assign next_a = head.chain ? res_data : head.a;
`else
   assign next_a = head.a;
`endif

   fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (cmd_valid),
      .push_rdy (cmd_ready),
      .push_dat (push_cmd),
      .pop_vld  (head_vld),
      .pop_rdy  (pop),
      .pop_dat  (head_raw),
      .level    (fifo_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_ctrl  <= 1'b0;
         alu_s     <= 2'b00;
         res_data  <= '0;
         res_seq   <= '0;
         issue_cnt <= '0;
      end else begin
         if (pop) begin
            alu_a    <= next_a;
            alu_b    <= head.b;
            alu_ctrl <= head.ctrl;
            alu_s    <= head.s;
         end
         case (state)
            IDLE: if (head_vld) state <= DRIVE;
            DRIVE: begin
               // alu_y has had one full cycle to settle from the registered operands.
               res_data  <= alu_y;
               res_seq   <= issue_cnt;
               issue_cnt <= issue_cnt + 8'd1;
               state     <= HOLD;
            end
            HOLD: if (res_ready) state <= head_vld ? DRIVE : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign res_valid = (state == HOLD);
   assign busy      = (state != IDLE) || head_vld;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; ALU stubbed as alu_y = alu_a ^ alu_b.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_alu_issue_ctrl;
   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic       cmd_ctrl;
   logic [1:0] cmd_s;
   logic       cmd_chain;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic       alu_ctrl;
   logic [1:0] alu_s;
   logic [7:0] alu_y;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic [7:0] res_seq;
   logic       busy;
   logic [2:0] fifo_level;

   int tests_run;
   int tests_failed;

   assign alu_y = alu_a ^ alu_b;

   alu_issue_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_ctrl   (cmd_ctrl),
      .cmd_s      (cmd_s),
`ifdef ALU_ISSUE_CHAIN_EN
      .cmd_chain  (cmd_chain),
`endif
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_s      (alu_s),
      .alu_y      (alu_y),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_seq    (res_seq),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_cmd(input logic [7:0] a, input logic [7:0] b, input logic ctrl,
                            input logic [1:0] s, input logic chain);
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_ctrl  = ctrl;
      cmd_s     = s;
      cmd_chain = chain;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_ctrl = 1'b0; cmd_s = '0; cmd_chain = 1'b0;
      #2;
      tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
      tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
      tests_run++; if (fifo_level !== 3'd0) begin tests_failed++; $display("FAIL reset_level got %0d want 0", fifo_level); end
      tests_run++; if ({alu_a, alu_b, alu_ctrl, alu_s} !== 19'd0) begin tests_failed++; $display("FAIL reset_alu_regs got %h/%h/%b/%b want 0", alu_a, alu_b, alu_ctrl, alu_s); end
      tests_run++; if ({res_data, res_seq} !== 16'd0) begin tests_failed++; $display("FAIL reset_result got %h/%0d want 0/0", res_data, res_seq); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      apply_reset();
      res_ready = 1'b1;
      drive_cmd(8'hBF, 8'h33, 1'b1, 2'b11, 1'b0);
      tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL single_ready got %b want 1", cmd_ready); end
      tick();
      cmd_valid = 1'b0;
      tests_run++; if (res_valid !== 1'b0 || fifo_level !== 3'd1 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_n0 got valid=%b level=%0d busy=%b want 0/1/1", res_valid, fifo_level, busy); end
      tick();
      tests_run++; if (res_valid !== 1'b0 || fifo_level !== 3'd0) begin tests_failed++; $display("FAIL single_n1 got valid=%b level=%0d want 0/0", res_valid, fifo_level); end
      tests_run++; if ({alu_a, alu_b, alu_ctrl, alu_s} !== {8'hBF, 8'h33, 1'b1, 2'b11}) begin tests_failed++; $display("FAIL single_operands got %h/%h/%b/%b want bf/33/1/11", alu_a, alu_b, alu_ctrl, alu_s); end
      tick();
      tests_run++; if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL single_latency got valid=%b want 1", res_valid); end
      tests_run++; if (res_data !== 8'h8C || res_seq !== 8'd0) begin tests_failed++; $display("FAIL single_result got %h seq %0d want 8c seq 0", res_data, res_seq); end
      tick();
      tests_run++; if (res_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL single_done got valid=%b busy=%b want 0/0", res_valid, busy); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ta [4];
      logic [7:0] tb [4];
      logic [7:0] ty [4];
      int r;
      ta = '{8'h01, 8'h22, 8'h43, 8'h84};
      tb = '{8'h10, 8'h10, 8'h0F, 8'hF0};
      ty = '{8'h11, 8'h32, 8'h4C, 8'h74};
      apply_reset();
      res_ready = 1'b1;
      r = 0;
      for (int k = 0; k < 11; k++) begin
         if (k < 4) drive_cmd(ta[k], tb[k], 1'b0, 2'b01, 1'b0);
         else cmd_valid = 1'b0;
         if (k < 4) begin
            tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready k=%0d got %b want 1", k, cmd_ready); end
         end
         tick();
         tests_run++;
         if (res_valid !== ((k == 2) || (k == 4) || (k == 6) || (k == 8))) begin
            tests_failed++; $display("FAIL b2b_valid k=%0d got %b", k, res_valid);
         end
         if (res_valid === 1'b1 && r < 4) begin
            tests_run++;
            if (res_data !== ty[r] || res_seq !== 8'(r)) begin
               tests_failed++; $display("FAIL b2b_result %0d got %h seq %0d want %h seq %0d", r, res_data, res_seq, ty[r], r);
            end
            r++;
         end
      end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      logic [7:0] ty [6];
      int n;
      ty = '{8'hAF, 8'hAE, 8'hAD, 8'hAC, 8'hAB, 8'hAA};
      apply_reset();
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_cmd(8'hA0 + 8'(i), 8'h0F, 1'b0, 2'b10, 1'b0);
         tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_fill_ready i=%0d got %b want 1", i, cmd_ready); end
         tick();
      end
      tests_run++; if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full got level=%0d ready=%b want 4/0", fifo_level, cmd_ready); end
      tests_run++; if (res_valid !== 1'b1 || res_data !== 8'hAF || res_seq !== 8'd0) begin tests_failed++; $display("FAIL bp_held got valid=%b %h seq %0d want 1 af 0", res_valid, res_data, res_seq); end
      drive_cmd(8'hA5, 8'h0F, 1'b0, 2'b10, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++; if (cmd_ready !== 1'b0 || fifo_level !== 3'd4 || res_data !== 8'hAF || res_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_stall i=%0d got ready=%b level=%0d data=%h valid=%b", i, cmd_ready, fifo_level, res_data, res_valid); end
      end
      res_ready = 1'b1;
      tick();
      tests_run++; if (fifo_level !== 3'd3 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_pop got level=%0d valid=%b ready=%b want 3/0/1", fifo_level, res_valid, cmd_ready); end
      tick();
      cmd_valid = 1'b0;
      tests_run++; if (fifo_level !== 3'd4 || res_valid !== 1'b1 || res_data !== 8'hAE || res_seq !== 8'd1) begin tests_failed++; $display("FAIL bp_sixth got level=%0d valid=%b %h seq %0d want 4/1/ae/1", fifo_level, res_valid, res_data, res_seq); end
      n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         tick();
         if (res_valid === 1'b1) begin
            tests_run++;
            if (res_data !== ty[n+2] || res_seq !== 8'(n+2)) begin
               tests_failed++; $display("FAIL bp_drain %0d got %h seq %0d want %h seq %0d", n+2, res_data, res_seq, ty[n+2], n+2);
            end
            n++;
         end
      end
      tests_run++; if (n != 4) begin tests_failed++; $display("FAIL bp_drain_timeout got %0d results want 4", n); end
      tick();
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_cmd(8'hB0 + 8'(i), 8'h00, 1'b1, 2'b01, 1'b0);
         tick();
      end
      cmd_valid = 1'b0;
      tests_run++; if (res_valid !== 1'b1 || fifo_level !== 3'd3) begin tests_failed++; $display("FAIL mid_setup got valid=%b level=%0d want 1/3", res_valid, fifo_level); end
      #2 rst_n = 1'b0;
      #1;
      tests_run++; if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || fifo_level !== 3'd0) begin tests_failed++; $display("FAIL mid_status got valid=%b busy=%b ready=%b level=%0d want 0/0/1/0", res_valid, busy, cmd_ready, fifo_level); end
      tests_run++; if ({alu_a, alu_b, alu_ctrl, alu_s} !== 19'd0 || {res_data, res_seq} !== 16'd0) begin tests_failed++; $display("FAIL mid_regs got %h/%h/%b/%b res %h/%0d want zeros", alu_a, alu_b, alu_ctrl, alu_s, res_data, res_seq); end
      @(negedge clk);
      rst_n = 1'b1;
      res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests_run++; if (res_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_stale i=%0d got valid=%b busy=%b want 0/0", i, res_valid, busy); end
      end
      drive_cmd(8'h5A, 8'hA5, 1'b0, 2'b00, 1'b0);
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      tests_run++; if (res_valid !== 1'b1 || res_data !== 8'hFF || res_seq !== 8'd0) begin tests_failed++; $display("FAIL mid_after got valid=%b %h seq %0d want 1 ff 0", res_valid, res_data, res_seq); end
      tick();
   endtask

   task automatic test_seq_wrap();
      int acc;
      int nres;
      apply_reset();
      res_ready = 1'b1;
      acc = 0;
      nres = 0;
      for (int cyc = 0; cyc < 1500 && nres < 257; cyc++) begin
         if (res_valid === 1'b1) begin
            tests_run++;
            if (res_seq !== nres[7:0] || res_data !== nres[7:0]) begin
               tests_failed++; $display("FAIL wrap_result %0d got data %h seq %0d want %h", nres, res_data, res_seq, nres[7:0]);
            end
            nres++;
         end
         if (acc < 257) drive_cmd(acc[7:0], 8'h00, 1'b0, 2'b00, 1'b0);
         else cmd_valid = 1'b0;
         if (cmd_valid && cmd_ready) acc++;
         tick();
      end
      cmd_valid = 1'b0;
      tests_run++; if (nres != 257) begin tests_failed++; $display("FAIL wrap_timeout got %0d results want 257", nres); end
   endtask

`ifdef ALU_ISSUE_CHAIN_EN
   task automatic test_chain();
      logic [7:0] ty [2];
      int n;
      ty = '{8'hFF, 8'h00};
      apply_reset();
      res_ready = 1'b1;
      drive_cmd(8'h0F, 8'hF0, 1'b0, 2'b00, 1'b0);
      tick();
      drive_cmd(8'h00, 8'hFF, 1'b0, 2'b00, 1'b1);
      tick();
      cmd_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 20 && n < 2; c++) begin
         if (res_valid === 1'b1) begin
            tests_run++;
            if (res_data !== ty[n]) begin tests_failed++; $display("FAIL chain_result %0d got %h want %h", n, res_data, ty[n]); end
            n++;
         end
         tick();
      end
      tests_run++; if (n != 2) begin tests_failed++; $display("FAIL chain_timeout got %0d results want 2", n); end
   endtask
`endif

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_seq_wrap();
`ifdef ALU_ISSUE_CHAIN_EN
      test_chain();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
